// File: rtl/nvcm_recall_seq_if.sv
// Bitstream handshake between the recall sequencer and the configuration loader.
// The master holds bs_data stable while bs_valid is high until bs_ready accepts it.
interface nvcm_recall_seq_if #(
    parameter int DATA_W = 9
) ();
    logic [DATA_W-1:0] bs_data;
    logic              bs_valid;
    logic              bs_ready;

    modport master (output bs_data, output bs_valid, input bs_ready);
    modport slave  (input bs_data, input bs_valid, output bs_ready);
endinterface

// File: rtl/nvcm_recall_seq.sv
// NVCM recall sequencer: walks blk/row/col up to latched limits and streams each word out.
// Latency: 1+PWRUP_CYC+1+RD_WAIT+1 cycles from start to first bs_valid, then RD_WAIT+4 per word.
// Backpressure: PUSH holds bs_data/bs_valid until bs_ready; NVCM_PARITY_CHK_EN enables odd-parity abort.
module nvcm_recall_seq #(
    parameter int ROW_W     = 9,
    parameter int COL_W     = 12,
    parameter int BLK_W     = 4,
    parameter int DATA_W    = 9,
    parameter int RD_WAIT   = 3,
    parameter int PWRUP_CYC = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ROW_W-1:0]  max_rowadd,
    input  logic [COL_W-1:0]  max_coladd,
    input  logic [BLK_W-1:0]  max_blkadd,
    input  logic              margin_rd,
    input  logic [DATA_W-1:0] nv_dataout,
    output logic              fsm_nvcmen,
    output logic              fsm_rd,
    output logic              fsm_sample,
    output logic [ROW_W-1:0]  fsm_rowadd,
    output logic [COL_W-1:0]  fsm_coladd,
    output logic [BLK_W-1:0]  fsm_blkadd,
    output logic [BLK_W-1:0]  fsm_blkadd_b,
    output logic              fsm_tm_margin0_read,
    nvcm_recall_seq_if.master bs,
    output logic              nvcm_boot,
    output logic              nvcm_rdy,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE, S_PWRUP, S_ADDR, S_READ, S_SAMPLE, S_PUSH, S_NEXT, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        cnt_q;
    logic [ROW_W-1:0]  row_q, max_row_q;
    logic [COL_W-1:0]  col_q, max_col_q;
    logic [BLK_W-1:0]  blk_q, max_blk_q;
    logic              margin_q;
    logic [DATA_W-1:0] data_q;
    logic              busy;
    logic              last_col, last_row, last_blk, last_word;
    logic              accept_start;
    logic              parity_bad;

    assign last_col     = (col_q == max_col_q);
    assign last_row     = (row_q == max_row_q);
    assign last_blk     = (blk_q == max_blk_q);
    assign last_word    = last_col && last_row && last_blk;
    assign accept_start = start && ((state_q == S_IDLE) || (state_q == S_DONE));

`ifdef NVCM_PARITY_CHK_EN
    logic err_q;

    // Stored MSB makes the whole word odd-weight; an even-weight word is corrupt.
    assign parity_bad = ~(^nv_dataout);
    assign err        = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (accept_start) begin
            err_q <= 1'b0;
        end else if (state_q == S_SAMPLE && parity_bad) begin
            err_q <= 1'b1;
        end
    end
`else
    assign parity_bad = 1'b0;
    assign err        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        busy        = 1'b0;
        fsm_rd      = 1'b0;
        fsm_sample  = 1'b0;
        bs.bs_valid = 1'b0;
        nvcm_rdy    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept_start) state_d = S_PWRUP;
            end
            S_PWRUP: begin
                busy = 1'b1;
                if (cnt_q == 8'(PWRUP_CYC - 1)) state_d = S_ADDR;
            end
            S_ADDR: begin
                busy    = 1'b1;
                state_d = S_READ;
            end
            S_READ: begin
                busy   = 1'b1;
                fsm_rd = 1'b1;
                if (cnt_q == 8'(RD_WAIT - 1)) state_d = S_SAMPLE;
            end
            S_SAMPLE: begin
                busy       = 1'b1;
                fsm_rd     = 1'b1;
                fsm_sample = 1'b1;
                state_d    = parity_bad ? S_DONE : S_PUSH;
            end
            S_PUSH: begin
                busy        = 1'b1;
                bs.bs_valid = 1'b1;
                if (bs.bs_ready) state_d = S_NEXT;
            end
            S_NEXT: begin
                busy    = 1'b1;
                state_d = last_word ? S_DONE : S_ADDR;
            end
            S_DONE: begin
                nvcm_rdy = 1'b1;
                if (accept_start) state_d = S_PWRUP;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            row_q     <= '0;
            col_q     <= '0;
            blk_q     <= '0;
            max_row_q <= '0;
            max_col_q <= '0;
            max_blk_q <= '0;
            margin_q  <= 1'b0;
            data_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (accept_start) begin
                        max_row_q <= max_rowadd;
                        max_col_q <= max_coladd;
                        max_blk_q <= max_blkadd;
                        margin_q  <= margin_rd;
                        row_q     <= '0;
                        col_q     <= '0;
                        blk_q     <= '0;
                        cnt_q     <= '0;
                    end
                end
                S_PWRUP:  cnt_q <= cnt_q + 8'd1;
                S_ADDR:   cnt_q <= '0;
                S_READ:   cnt_q <= cnt_q + 8'd1;
                S_SAMPLE: begin
                    if (!parity_bad) data_q <= nv_dataout;
                end
                S_NEXT: begin
                    // Column runs fastest; the final word leaves the address parked.
                    if (!last_word) begin
                        if (!last_col) begin
                            col_q <= col_q + 1'b1;
                        end else begin
                            col_q <= '0;
                            if (!last_row) begin
                                row_q <= row_q + 1'b1;
                            end else begin
                                row_q <= '0;
                                blk_q <= blk_q + 1'b1;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign fsm_nvcmen          = busy;
    assign nvcm_boot           = busy;
    assign fsm_tm_margin0_read = busy && margin_q;
    assign fsm_rowadd          = row_q;
    assign fsm_coladd          = col_q;
    assign fsm_blkadd          = blk_q;
    assign fsm_blkadd_b        = ~blk_q;
    assign bs.bs_data          = data_q;

endmodule

// File: tb/tb_nvcm_recall_seq.sv
// Randomized bench for nvcm_recall_seq against a nested-loop reference of the recall order.
module tb_nvcm_recall_seq;
    localparam int ROW_W = 9, COL_W = 12, BLK_W = 4, DATA_W = 9;
    localparam int RD_WAIT = 3, PWRUP_CYC = 4;
    localparam int FIRST_LAT = 1 + PWRUP_CYC + 1 + RD_WAIT + 1;
    localparam int WORD_CYC  = RD_WAIT + 4;

    logic clk = 1'b0;
    logic rst, start, margin_rd;
    logic [ROW_W-1:0]  max_rowadd, fsm_rowadd;
    logic [COL_W-1:0]  max_coladd, fsm_coladd;
    logic [BLK_W-1:0]  max_blkadd, fsm_blkadd, fsm_blkadd_b;
    logic [DATA_W-1:0] nv_dataout;
    logic fsm_nvcmen, fsm_rd, fsm_sample, fsm_tm_margin0_read, nvcm_boot, nvcm_rdy, err;

    nvcm_recall_seq_if #(.DATA_W(DATA_W)) bs_if ();

    nvcm_recall_seq #(
        .ROW_W(ROW_W), .COL_W(COL_W), .BLK_W(BLK_W), .DATA_W(DATA_W),
        .RD_WAIT(RD_WAIT), .PWRUP_CYC(PWRUP_CYC)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .max_rowadd(max_rowadd), .max_coladd(max_coladd), .max_blkadd(max_blkadd),
        .margin_rd(margin_rd), .nv_dataout(nv_dataout),
        .fsm_nvcmen(fsm_nvcmen), .fsm_rd(fsm_rd), .fsm_sample(fsm_sample),
        .fsm_rowadd(fsm_rowadd), .fsm_coladd(fsm_coladd),
        .fsm_blkadd(fsm_blkadd), .fsm_blkadd_b(fsm_blkadd_b),
        .fsm_tm_margin0_read(fsm_tm_margin0_read),
        .bs(bs_if.master),
        .nvcm_boot(nvcm_boot), .nvcm_rdy(nvcm_rdy), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0, cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [BLK_W-1:0]  blk, blk_b;
        logic [ROW_W-1:0]  row;
        logic [COL_W-1:0]  col;
        logic              margin;
        int                cyc;
    } xfer_t;
    typedef struct {
        logic [DATA_W-1:0] data;
        logic [BLK_W-1:0]  blk;
        logic [ROW_W-1:0]  row;
        logic [COL_W-1:0]  col;
    } exp_t;

    xfer_t got_q[$];
    exp_t  exp_q[$];
    logic  exp_err;

    logic [31:0]      seed = 32'h1;
    logic             bad_en = 1'b0;
    logic [BLK_W-1:0] bad_b = '0;
    logic [ROW_W-1:0] bad_r = '0;
    logic [COL_W-1:0] bad_c = '0;

    // Array contents: hashed from the address, odd parity when the check is built in.
    function automatic logic [DATA_W-1:0] mem_word(input logic [BLK_W-1:0] b, input logic [ROW_W-1:0] r,
                                                   input logic [COL_W-1:0] c, input logic [31:0] s,
                                                   input logic be, input logic [BLK_W-1:0] bb,
                                                   input logic [ROW_W-1:0] br, input logic [COL_W-1:0] bc);
        logic [31:0] h;
        logic [DATA_W-1:0] w;
        h = s ^ (32'(b) * 32'd2654435761) ^ (32'(r) * 32'd40503) ^ (32'(c) * 32'd977);
        h = h ^ (h >> 13);
        w = h[DATA_W-1:0];
`ifdef NVCM_PARITY_CHK_EN
        w[DATA_W-1] = ~(^w[DATA_W-2:0]);
`endif
        if (be && b == bb && r == br && c == bc) w = '0;
        return w;
    endfunction

    always_comb nv_dataout = mem_word(fsm_blkadd, fsm_rowadd, fsm_coladd, seed, bad_en, bad_b, bad_r, bad_c);

    task automatic build_exp(input int nb, input int nr, input int nc);
        logic stop;
        exp_t e;
        exp_q.delete();
        exp_err = 1'b0;
        stop = 1'b0;
        for (int b = 0; b <= nb; b++)
            for (int r = 0; r <= nr; r++)
                for (int c = 0; c <= nc; c++) begin
                    if (!stop) begin
                        e.blk = BLK_W'(b); e.row = ROW_W'(r); e.col = COL_W'(c);
                        e.data = mem_word(e.blk, e.row, e.col, seed, bad_en, bad_b, bad_r, bad_c);
`ifdef NVCM_PARITY_CHK_EN
                        if (!(^e.data)) begin
                            exp_err = 1'b1;
                            stop = 1'b1;
                        end
`endif
                        if (!stop) exp_q.push_back(e);
                    end
                end
    endtask

    // Stream monitor: records transfers and watches handshake invariants.
    logic prev_stall = 1'b0;
    xfer_t prev_x, mon_x;
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            checks++;
            if (fsm_blkadd_b !== ~fsm_blkadd) begin
                errors++; $display("FAIL blkadd_b got %h required %h", fsm_blkadd_b, ~fsm_blkadd);
            end
            checks++;
            if (bs_if.bs_valid && fsm_rd) begin
                errors++; $display("FAIL rd_in_push got fsm_rd=1 required 0");
            end
            if (prev_stall) begin
                checks++;
                if (bs_if.bs_valid !== 1'b1 || bs_if.bs_data !== prev_x.data ||
                    {fsm_blkadd, fsm_rowadd, fsm_coladd} !== {prev_x.blk, prev_x.row, prev_x.col}) begin
                    errors++;
                    $display("FAIL stall_hold got v=%b d=%h required v=1 d=%h", bs_if.bs_valid, bs_if.bs_data, prev_x.data);
                end
            end
            mon_x.data = bs_if.bs_data; mon_x.blk = fsm_blkadd; mon_x.blk_b = fsm_blkadd_b;
            mon_x.row = fsm_rowadd; mon_x.col = fsm_coladd; mon_x.margin = fsm_tm_margin0_read;
            mon_x.cyc = cyc;
            if (bs_if.bs_valid && bs_if.bs_ready) got_q.push_back(mon_x);
            prev_stall = bs_if.bs_valid && !bs_if.bs_ready;
            prev_x = mon_x;
        end
    end

    task automatic do_start(input int nb, input int nr, input int nc, input logic m, output int sc);
        max_blkadd = BLK_W'(nb); max_rowadd = ROW_W'(nr); max_coladd = COL_W'(nc);
        margin_rd = m;
        got_q.delete();
        start = 1'b1;
        @(posedge clk); #1;
        sc = cyc;
        start = 1'b0;
        max_blkadd = BLK_W'($urandom); max_rowadd = ROW_W'($urandom); max_coladd = COL_W'($urandom);
        margin_rd = 1'($urandom);
    endtask

    task automatic wait_done(input int pct, output bit to);
        int n = 0;
        while (!nvcm_rdy && n < 3000) begin
            @(posedge clk); #1;
            bs_if.bs_ready = (int'($urandom_range(99)) < pct);
            n++;
        end
        to = !nvcm_rdy;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; margin_rd = 1'b0; bs_if.bs_ready = 1'b0;
        max_blkadd = '0; max_rowadd = '0; max_coladd = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({fsm_nvcmen, fsm_rd, fsm_sample, nvcm_boot, nvcm_rdy, err, fsm_tm_margin0_read, bs_if.bs_valid} !== 8'b0) begin
            errors++; $display("FAIL reset_ctrl got %b required 00000000",
                {fsm_nvcmen, fsm_rd, fsm_sample, nvcm_boot, nvcm_rdy, err, fsm_tm_margin0_read, bs_if.bs_valid});
        end
        checks++;
        if ({fsm_blkadd, fsm_rowadd, fsm_coladd} !== '0) begin
            errors++; $display("FAIL reset_addr got %h/%h/%h required 0", fsm_blkadd, fsm_rowadd, fsm_coladd);
        end
        checks++;
        if (fsm_blkadd_b !== 4'hF) begin
            errors++; $display("FAIL reset_blkadd_b got %h required f", fsm_blkadd_b);
        end
        checks++;
        if (bs_if.bs_data !== '0) begin
            errors++; $display("FAIL reset_data got %h required 0", bs_if.bs_data);
        end
    endtask

    task automatic test_basic;
        int sc; bit to;
        seed = $urandom; bad_en = 1'b0;
        build_exp(0, 1, 2);
        bs_if.bs_ready = 1'b1;
        do_start(0, 1, 2, 1'b0, sc);
        wait_done(100, to);
        checks++;
        if (to || got_q.size() != 6) begin
            errors++; $display("FAIL basic_count got %0d timeout=%0d required 6", got_q.size(), to);
        end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            checks++;
            if ({got_q[i].data, got_q[i].blk, got_q[i].row, got_q[i].col} !== {exp_q[i].data, exp_q[i].blk, exp_q[i].row, exp_q[i].col}) begin
                errors++; $display("FAIL basic_word%0d got %h@%0d,%0d required %h@%0d,%0d", i,
                    got_q[i].data, got_q[i].row, got_q[i].col, exp_q[i].data, exp_q[i].row, exp_q[i].col);
            end
            if (i > 0) begin
                checks++;
                if (got_q[i].cyc - got_q[i-1].cyc != WORD_CYC) begin
                    errors++; $display("FAIL basic_period%0d got %0d required %0d", i, got_q[i].cyc - got_q[i-1].cyc, WORD_CYC);
                end
            end
        end
        if (got_q.size() > 0) begin
            checks++;
            if (got_q[0].cyc - sc + 1 != FIRST_LAT) begin
                errors++; $display("FAIL basic_latency got %0d required %0d", got_q[0].cyc - sc + 1, FIRST_LAT);
            end
        end
        checks++;
        if (nvcm_rdy !== 1'b1 || nvcm_boot !== 1'b0 || fsm_nvcmen !== 1'b0) begin
            errors++; $display("FAIL basic_done got rdy=%b boot=%b en=%b required 1 0 0", nvcm_rdy, nvcm_boot, fsm_nvcmen);
        end
    endtask

    task automatic test_blocks;
        int sc; bit to;
        seed = $urandom;
        build_exp(2, 0, 0);
        bs_if.bs_ready = 1'b1;
        do_start(2, 0, 0, 1'b0, sc);
        wait_done(100, to);
        checks++;
        if (to || got_q.size() != 3) begin
            errors++; $display("FAIL blocks_count got %0d required 3", got_q.size());
        end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            checks++;
            if ({got_q[i].data, got_q[i].blk, got_q[i].blk_b} !== {exp_q[i].data, exp_q[i].blk, ~exp_q[i].blk}) begin
                errors++; $display("FAIL blocks_word%0d got %h blk=%h b=%h required %h blk=%h", i,
                    got_q[i].data, got_q[i].blk, got_q[i].blk_b, exp_q[i].data, exp_q[i].blk);
            end
        end
    endtask

    task automatic test_stall;
        int sc, n; bit to;
        logic [DATA_W-1:0] hd;
        logic [ROW_W+COL_W-1:0] ha;
        seed = $urandom;
        build_exp(0, 1, 2);
        bs_if.bs_ready = 1'b1;
        do_start(0, 1, 2, 1'b0, sc);
        n = 0;
        while (got_q.size() < 1 && n < 200) begin @(posedge clk); #1; n++; end
        bs_if.bs_ready = 1'b0;
        n = 0;
        while (!bs_if.bs_valid && n < 200) begin @(posedge clk); #1; n++; end
        checks++;
        if (!bs_if.bs_valid) begin
            errors++; $display("FAIL stall_valid got 0 required 1");
        end
        hd = bs_if.bs_data; ha = {fsm_rowadd, fsm_coladd};
        repeat (5) begin
            @(posedge clk); #1;
            checks++;
            if (bs_if.bs_valid !== 1'b1 || bs_if.bs_data !== hd || {fsm_rowadd, fsm_coladd} !== ha || fsm_rd !== 1'b0) begin
                errors++; $display("FAIL stall_cycle got v=%b d=%h rd=%b required v=1 d=%h rd=0", bs_if.bs_valid, bs_if.bs_data, fsm_rd, hd);
            end
        end
        bs_if.bs_ready = 1'b1;
        wait_done(100, to);
        checks++;
        if (to || got_q.size() != exp_q.size()) begin
            errors++; $display("FAIL stall_count got %0d required %0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            checks++;
            if ({got_q[i].data, got_q[i].row, got_q[i].col} !== {exp_q[i].data, exp_q[i].row, exp_q[i].col}) begin
                errors++; $display("FAIL stall_word%0d got %h required %h", i, got_q[i].data, exp_q[i].data);
            end
        end
    endtask

    task automatic test_start_busy;
        int sc, n; bit to;
        seed = $urandom;
        build_exp(0, 1, 2);
        bs_if.bs_ready = 1'b0;
        do_start(0, 1, 2, 1'b0, sc);
        n = 0;
        while (!bs_if.bs_valid && n < 200) begin @(posedge clk); #1; n++; end
        start = 1'b1; bs_if.bs_ready = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done(100, to);
        checks++;
        if (to || got_q.size() != 6) begin
            errors++; $display("FAIL busy_start_count got %0d required 6", got_q.size());
        end
        build_exp(1, 1, 1);
        do_start(1, 1, 1, 1'b1, sc);
        checks++;
        if (nvcm_rdy !== 1'b0 || fsm_tm_margin0_read !== 1'b1) begin
            errors++; $display("FAIL restart_flags got rdy=%b margin=%b required 0 1", nvcm_rdy, fsm_tm_margin0_read);
        end
        wait_done(70, to);
        checks++;
        if (to || got_q.size() != 8) begin
            errors++; $display("FAIL margin_count got %0d required 8", got_q.size());
        end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            checks++;
            if ({got_q[i].margin, got_q[i].data, got_q[i].blk, got_q[i].row, got_q[i].col} !==
                {1'b1, exp_q[i].data, exp_q[i].blk, exp_q[i].row, exp_q[i].col}) begin
                errors++; $display("FAIL margin_word%0d got m=%b %h required m=1 %h", i, got_q[i].margin, got_q[i].data, exp_q[i].data);
            end
        end
        checks++;
        if (fsm_tm_margin0_read !== 1'b0) begin
            errors++; $display("FAIL margin_done got 1 required 0");
        end
    endtask

    task automatic test_reset_mid;
        int sc, n, cnt; bit to;
        seed = $urandom;
        build_exp(0, 1, 2);
        bs_if.bs_ready = 1'b1;
        do_start(0, 1, 2, 1'b0, sc);
        n = 0;
        while (!(got_q.size() == 2 && fsm_rd && !fsm_sample) && n < 300) begin @(posedge clk); #1; n++; end
        cnt = got_q.size();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) begin
            checks++;
            if ({fsm_nvcmen, fsm_rd, fsm_sample, nvcm_boot, nvcm_rdy, bs_if.bs_valid, fsm_blkadd, fsm_rowadd, fsm_coladd, bs_if.bs_data} !== '0
                || fsm_blkadd_b !== 4'hF) begin
                errors++; $display("FAIL midreset_state got en=%b rd=%b v=%b col=%h d=%h required all 0",
                    fsm_nvcmen, fsm_rd, bs_if.bs_valid, fsm_coladd, bs_if.bs_data);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (got_q.size() != 2 || cnt != 2) begin
            errors++; $display("FAIL midreset_words got %0d required 2", got_q.size());
        end
        do_start(0, 1, 2, 1'b0, sc);
        wait_done(100, to);
        checks++;
        if (to || got_q.size() != 6) begin
            errors++; $display("FAIL midreset_rerun got %0d required 6", got_q.size());
        end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            checks++;
            if ({got_q[i].data, got_q[i].row, got_q[i].col} !== {exp_q[i].data, exp_q[i].row, exp_q[i].col}) begin
                errors++; $display("FAIL midreset_word%0d got %h required %h", i, got_q[i].data, exp_q[i].data);
            end
        end
    endtask

    task automatic test_bad_word;
        int sc; bit to;
        seed = $urandom;
        bad_en = 1'b1; bad_b = '0; bad_r = '0; bad_c = 12'd1;
        build_exp(0, 1, 2);
        bs_if.bs_ready = 1'b1;
        do_start(0, 1, 2, 1'b0, sc);
        wait_done(100, to);
        checks++;
        if (to || got_q.size() != exp_q.size() || err !== exp_err || nvcm_rdy !== 1'b1) begin
            errors++; $display("FAIL bad_word got n=%0d err=%b rdy=%b required n=%0d err=%b rdy=1",
                got_q.size(), err, nvcm_rdy, exp_q.size(), exp_err);
        end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            checks++;
            if (got_q[i].data !== exp_q[i].data) begin
                errors++; $display("FAIL bad_word%0d got %h required %h", i, got_q[i].data, exp_q[i].data);
            end
        end
        bad_en = 1'b0;
        build_exp(0, 1, 2);
        do_start(0, 1, 2, 1'b0, sc);
        checks++;
        if (err !== 1'b0) begin
            errors++; $display("FAIL err_clear got %b required 0", err);
        end
        wait_done(100, to);
        checks++;
        if (to || got_q.size() != 6 || err !== 1'b0) begin
            errors++; $display("FAIL bad_rerun got n=%0d err=%b required 6 0", got_q.size(), err);
        end
    endtask

    task automatic test_random;
        int sc, nb, nr, nc, pct; bit to; logic m;
        for (int it = 0; it < 5; it++) begin
            seed = $urandom;
            nb = int'($urandom_range(2)); nr = int'($urandom_range(2)); nc = int'($urandom_range(3));
            pct = int'($urandom_range(100, 30)); m = 1'($urandom);
            build_exp(nb, nr, nc);
            bs_if.bs_ready = 1'b1;
            do_start(nb, nr, nc, m, sc);
            wait_done(pct, to);
            checks++;
            if (to || got_q.size() != (nb + 1) * (nr + 1) * (nc + 1)) begin
                errors++; $display("FAIL rand%0d_count got %0d required %0d", it, got_q.size(), (nb + 1) * (nr + 1) * (nc + 1));
            end
            foreach (exp_q[i]) if (i < got_q.size()) begin
                checks++;
                if ({got_q[i].margin, got_q[i].data, got_q[i].blk, got_q[i].row, got_q[i].col} !==
                    {m, exp_q[i].data, exp_q[i].blk, exp_q[i].row, exp_q[i].col}) begin
                    errors++; $display("FAIL rand%0d_word%0d got %h@%0d,%0d,%0d required %h@%0d,%0d,%0d", it, i,
                        got_q[i].data, got_q[i].blk, got_q[i].row, got_q[i].col,
                        exp_q[i].data, exp_q[i].blk, exp_q[i].row, exp_q[i].col);
                end
            end
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_blocks;
        test_stall;
        test_start_busy;
        test_reset_mid;
        test_bad_word;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got no finish required finish");
        $fatal(1);
    end
endmodule
